bit_serializer: RTL



---
 rtl/bit_serializer.sv | 84 ++++++++
 1 files changed

// File: rtl/bit_serializer.sv
// bit_serializer: captures a DATA_SIZE-bit word on start and emits it MSB first, one bit per clock.
// Ports: clk; rst_n (async, active low); start + data_in (capture request and word);
// data_out / data_out_enable / data_out_last (serial bit, valid qualifier, final-bit marker);
// ready (one-cycle pulse once the word is fully emitted and the block is idle).
// Optional BIT_SERIALIZER_PARITY_EN appends an even-parity bit after bit 0.
module bit_serializer #(
  parameter int DATA_SIZE = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DATA_SIZE-1:0] data_in,
  output logic                 data_out,
  output logic                 data_out_enable,
  output logic                 data_out_last,
  output logic                 ready
);
  localparam int CW = $clog2(DATA_SIZE + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_SIZE - 1);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
`ifdef BIT_SERIALIZER_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
  logic par;
`endif
  logic [1:0]           state;
  logic [CW-1:0]        cnt;
  logic [DATA_SIZE-1:0] sreg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      sreg            <= '0;
      data_out        <= 1'b0;
      data_out_enable <= 1'b0;
      data_out_last   <= 1'b0;
      ready           <= 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
      par             <= 1'b0;
`endif
    end else begin
      data_out        <= 1'b0;
      data_out_enable <= 1'b0;
      data_out_last   <= 1'b0;
      // ready trails the last-bit marker by one cycle, so a reset mid-word never yields ready
      ready           <= data_out_last;
      case (state)
        SHIFT: begin
          data_out        <= sreg[DATA_SIZE-1];
          data_out_enable <= 1'b1;
          sreg            <= {sreg[DATA_SIZE-2:0], 1'b0};
          cnt             <= cnt + 1'b1;
`ifdef BIT_SERIALIZER_PARITY_EN
          par <= par ^ sreg[DATA_SIZE-1];
          if (cnt == LAST_CNT) state <= PARITY;
`else
          if (cnt == LAST_CNT) begin
            data_out_last <= 1'b1;
            state         <= IDLE;
          end
`endif
        end
`ifdef BIT_SERIALIZER_PARITY_EN
        PARITY: begin
          data_out        <= par;
          data_out_enable <= 1'b1;
          data_out_last   <= 1'b1;
          state           <= IDLE;
        end
`endif
        default: begin
          if (start) begin
            sreg  <= data_in;
            cnt   <= '0;
            state <= SHIFT;
`ifdef BIT_SERIALIZER_PARITY_EN
            par   <= 1'b0;
`endif
          end
        end
      endcase
    end
  end
endmodule
